// File: rtl/cmd_frame_if.sv
// Bundles the USB FIFO read side and the signal-generator config outputs of cmd_frame_ctrl.
// master: the controller; slave: the FIFO / consumer side.
interface cmd_frame_if;
    logic        rxf_n;
    logic [7:0]  d_in;
    logic        rd_n;
    logic [4:0]  state;
    logic [11:0] state_freq;
    logic [2:0]  state_amp;
    logic [7:0]  state_phase;
    logic        cfg_update;
    logic        frame_err;
    logic [7:0]  err_cnt;

    modport master (
        input  rxf_n, d_in,
        output rd_n, state, state_freq, state_amp, state_phase,
        output cfg_update, frame_err, err_cnt
    );

    modport slave (
        output rxf_n, d_in,
        input  rd_n, state, state_freq, state_amp, state_phase,
        input  cfg_update, frame_err, err_cnt
    );
endinterface

// File: rtl/cmd_frame_ctrl.sv
// USB FIFO byte reader plus command-frame parser that loads signal-generator config registers.
// Define CMD_CHECKSUM_EN to require a fifth XOR checksum byte (ADDR^DHI^DLO) per frame.
module cmd_frame_ctrl #(
    parameter int RD_LOW_CYC  = 6,
    parameter int RD_HIGH_CYC = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst,
    cmd_frame_if.master bus
);
    localparam int RC_MAX = (RD_LOW_CYC > RD_HIGH_CYC) ? RD_LOW_CYC : RD_HIGH_CYC;
    localparam int RC_W   = $clog2(RC_MAX + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {R_IDLE, R_LOW, R_HIGH} rd_state_t;
`ifdef CMD_CHECKSUM_EN
    typedef enum logic [2:0] {P_HDR, P_ADDR, P_DHI, P_DLO, P_CSUM} p_state_t;
`else
    typedef enum logic [2:0] {P_HDR, P_ADDR, P_DHI, P_DLO} p_state_t;
`endif

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    rd_state_t       rd_state, rd_state_nxt;
    logic [RC_W-1:0] rcnt;
    logic            last_low, last_high, rd_strobe, cap;
    logic            vld_p0;
    logic [7:0]      byte_p0;

    p_state_t        p_state, p_state_nxt;
    logic [TO_W-1:0] to_cnt;
    logic            to_expire;
    logic [7:0]      addr_p1;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]      dhi_p1;
    logic [7:0]      dlo_p1;
`else
    logic [3:0]      dhi_p1;
`endif
    logic [7:0]      dlo_w;
    logic            frame_end, csum_ok, addr_ok, commit_p1, reject_p1;

    logic            upd_p2;
    logic [4:0]      cfg_state;
    logic [11:0]     cfg_freq;
    logic [2:0]      cfg_amp;
    logic [7:0]      cfg_phase;
    logic            cfg_update_r, frame_err_r;
    logic [7:0]      err_cnt_r;

    assign last_low  = (rd_state == R_LOW)  && (rcnt == RC_W'(RD_LOW_CYC - 1));
    assign last_high = (rd_state == R_HIGH) && (rcnt == RC_W'(RD_HIGH_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= R_IDLE;
            rcnt     <= '0;
        end else begin
            rd_state <= rd_state_nxt;
            if (rd_state_nxt != rd_state) rcnt <= '0;
            else                          rcnt <= rcnt + 1'b1;
        end
    end

    // rxf_n is only looked at in R_IDLE, so a started strobe always runs to completion
    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            R_IDLE:  if (!bus.rxf_n) rd_state_nxt = R_LOW;
            R_LOW:   if (last_low)   rd_state_nxt = R_HIGH;
            R_HIGH:  if (last_high)  rd_state_nxt = R_IDLE;
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        rd_strobe = (rd_state == R_LOW);
        cap       = last_low;
    end

    assign bus.rd_n = ~rd_strobe;

    // stage p0: captured FIFO byte
    always_ff @(posedge clk) begin
        if (rst) vld_p0 <= 1'b0;
        else     vld_p0 <= cap;
        if (cap) byte_p0 <= bus.d_in;
    end

    assign to_expire = (p_state != P_HDR) && !vld_p0 && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            p_state <= P_HDR;
            to_cnt  <= '0;
        end else begin
            p_state <= p_state_nxt;
            if (vld_p0 || (p_state == P_HDR) || to_expire) to_cnt <= '0;
            else                                           to_cnt <= to_cnt + 1'b1;
        end
    end

    always_comb begin
        p_state_nxt = p_state;
        if (vld_p0) begin
            case (p_state)
                P_HDR:   if (byte_p0 == 8'hA5) p_state_nxt = P_ADDR;
                P_ADDR:  p_state_nxt = P_DHI;
                P_DHI:   p_state_nxt = P_DLO;
`ifdef CMD_CHECKSUM_EN
                P_DLO:   p_state_nxt = P_CSUM;
`endif
                default: p_state_nxt = P_HDR;
            endcase
        end else if (to_expire) begin
            p_state_nxt = P_HDR;
        end
    end

    // stage p1: frame fields held until the final byte arrives
    always_ff @(posedge clk) begin
        if (vld_p0 && (p_state == P_ADDR)) addr_p1 <= byte_p0;
        if (vld_p0 && (p_state == P_DHI))  dhi_p1  <= byte_p0[$bits(dhi_p1)-1:0];
`ifdef CMD_CHECKSUM_EN
        if (vld_p0 && (p_state == P_DLO))  dlo_p1  <= byte_p0;
`endif
    end

    always_comb begin
`ifdef CMD_CHECKSUM_EN
        frame_end = vld_p0 && (p_state == P_CSUM);
        dlo_w     = dlo_p1;
        csum_ok   = (byte_p0 == (addr_p1 ^ dhi_p1 ^ dlo_p1));
`else
        frame_end = vld_p0 && (p_state == P_DLO);
        dlo_w     = byte_p0;
        csum_ok   = 1'b1;
`endif
        addr_ok   = (addr_p1 >= 8'h01) && (addr_p1 <= 8'h04);
        commit_p1 = frame_end && addr_ok && csum_ok;
        reject_p1 = (frame_end && !(addr_ok && csum_ok)) || to_expire;
    end

    // stage p2: config registers load, cfg_update follows one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_state    <= '0;
            cfg_freq     <= '0;
            cfg_amp      <= '0;
            cfg_phase    <= '0;
            upd_p2       <= 1'b0;
            cfg_update_r <= 1'b0;
            frame_err_r  <= 1'b0;
            err_cnt_r    <= '0;
        end else begin
            if (commit_p1) begin
                case (addr_p1[2:0])
                    3'd1:    cfg_state <= dlo_w[4:0];
                    3'd2:    cfg_freq  <= {dhi_p1[3:0], dlo_w};
                    3'd3:    cfg_amp   <= dlo_w[2:0];
                    3'd4:    cfg_phase <= dlo_w;
                    default: ;
                endcase
            end
            upd_p2       <= commit_p1;
            cfg_update_r <= upd_p2;
            frame_err_r  <= reject_p1;
            if (reject_p1) err_cnt_r <= sat_inc(err_cnt_r);
        end
    end

    assign bus.state       = cfg_state;
    assign bus.state_freq  = cfg_freq;
    assign bus.state_amp   = cfg_amp;
    assign bus.state_phase = cfg_phase;
    assign bus.cfg_update  = cfg_update_r;
    assign bus.frame_err   = frame_err_r;
    assign bus.err_cnt     = err_cnt_r;
endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// Directed bench for cmd_frame_ctrl: strobe timing, frame decode, rejection, timeout and reset.
module tb_cmd_frame_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cmd_frame_if bus();

    cmd_frame_ctrl #(
        .RD_LOW_CYC (6),
        .RD_HIGH_CYC(8),
        .TIMEOUT_CYC(200)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int upd_hi = 0;
    int err_hi = 0;

    always @(negedge clk) begin
        if (bus.cfg_update === 1'b1) upd_hi++;
        if (bus.frame_err === 1'b1) err_hi++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rd(input logic lvl, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.rd_n === lvl) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $error("FAIL %s: timed out, observed rd_n %b expected %b", tag, bus.rd_n, lvl);
        end
    endtask

    task automatic count_level(input logic lvl, output int n);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.rd_n !== lvl) break;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.d_in  = b;
        bus.rxf_n = 1'b0;
        wait_rd(1'b0, "rd_fall");
        wait_rd(1'b1, "rd_rise");
        bus.rxf_n = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] addr, input logic [7:0] dhi, input logic [7:0] dlo);
        send_byte(8'hA5);
        send_byte(addr);
        send_byte(dhi);
        send_byte(dlo);
`ifdef CMD_CHECKSUM_EN
        send_byte(addr ^ dhi ^ dlo);
`endif
    endtask

    initial begin
        int lo1, hi1, lo2;
        int u0, e0;

        rst = 1'b1;
        bus.rxf_n = 1'b1;
        bus.d_in  = 8'h00;
        idle(3);
        check("rst_rd_n", bus.rd_n, 1);
        check("rst_state", bus.state, 0);
        check("rst_freq", bus.state_freq, 0);
        check("rst_amp", bus.state_amp, 0);
        check("rst_phase", bus.state_phase, 0);
        check("rst_cfg_update", bus.cfg_update, 0);
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_err_cnt", bus.err_cnt, 0);
        rst = 1'b0;
        idle(2);

        // rxf_n held low: strobe cadence
        bus.d_in  = 8'h00;
        bus.rxf_n = 1'b0;
        wait_rd(1'b0, "cad_fall");
        count_level(1'b0, lo1);
        count_level(1'b1, hi1);
        count_level(1'b0, lo2);
        bus.rxf_n = 1'b1;
        check("cad_low1", lo1, 6);
        check("cad_low2", lo2, 6);
        check("cad_high_ge8_le9", (hi1 >= 8) && (hi1 <= 9), 1);
        idle(20);

        // freq frame with exact update / pulse timing
        u0 = upd_hi;
        e0 = err_hi;
        send_frame(8'h02, 8'h0A, 8'hBC);
        check("freq_before_commit", bus.state_freq, 0);
        @(negedge clk);
        check("freq_after_commit", bus.state_freq, 12'hABC);
        check("cfg_upd_not_yet", bus.cfg_update, 0);
        @(negedge clk);
        check("cfg_upd_pulse", bus.cfg_update, 1);
        @(negedge clk);
        check("cfg_upd_end", bus.cfg_update, 0);
        idle(5);
        check("freq_upd_count", upd_hi - u0, 1);
        check("freq_state_kept", bus.state, 0);
        check("freq_amp_kept", bus.state_amp, 0);
        check("freq_phase_kept", bus.state_phase, 0);
        check("freq_no_err", err_hi - e0, 0);

        // junk before header is discarded silently
        u0 = upd_hi;
        e0 = err_hi;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_frame(8'h01, 8'h00, 8'h03);
        idle(5);
        check("junk_state", bus.state, 3);
        check("junk_no_err", err_hi - e0, 0);
        check("junk_upd_count", upd_hi - u0, 1);
        check("junk_freq_kept", bus.state_freq, 12'hABC);

        // unknown address rejected, then err_cnt saturation
        u0 = upd_hi;
        e0 = err_hi;
        send_frame(8'h07, 8'h00, 8'h01);
        idle(5);
        check("bad_addr_err_pulse", err_hi - e0, 1);
        check("bad_addr_err_cnt", bus.err_cnt, 1);
        check("bad_addr_no_upd", upd_hi - u0, 0);
        check("bad_addr_state_kept", bus.state, 3);
        for (int k = 0; k < 299; k++) send_frame(8'h07, 8'h00, 8'h01);
        idle(5);
        check("err_cnt_saturate", bus.err_cnt, 255);
        check("err_pulses_300", err_hi - e0, 300);

        // inter-byte timeout
        e0 = err_hi;
        send_byte(8'hA5);
        send_byte(8'h04);
        idle(250);
        check("timeout_err_pulse", err_hi - e0, 1);
        check("timeout_err_cnt_sat", bus.err_cnt, 255);
        check("timeout_phase_kept", bus.state_phase, 0);
        send_frame(8'h04, 8'h00, 8'h40);
        idle(5);
        check("after_timeout_phase", bus.state_phase, 8'h40);
        check("after_timeout_no_err", err_hi - e0, 1);

        // reset in the middle of the DHI strobe
        send_byte(8'hA5);
        send_byte(8'h01);
        bus.d_in  = 8'h00;
        bus.rxf_n = 1'b0;
        wait_rd(1'b0, "mid_rst_fall");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_rd_n", bus.rd_n, 1);
        @(negedge clk);
        check("mid_rst_state", bus.state, 0);
        check("mid_rst_freq", bus.state_freq, 0);
        check("mid_rst_amp", bus.state_amp, 0);
        check("mid_rst_phase", bus.state_phase, 0);
        check("mid_rst_err_cnt", bus.err_cnt, 0);
        check("mid_rst_cfg_update", bus.cfg_update, 0);
        rst = 1'b0;
        bus.rxf_n = 1'b1;
        idle(20);
        u0 = upd_hi;
        e0 = err_hi;
        send_frame(8'h03, 8'h00, 8'h05);
        idle(5);
        check("post_rst_amp", bus.state_amp, 5);
        check("post_rst_state", bus.state, 0);
        check("post_rst_upd", upd_hi - u0, 1);
        check("post_rst_no_err", err_hi - e0, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
